bcd_to_bin_converter: RTL and testbench



---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_sub3_adjust.sv | 14 +
 rtl/bcd_to_bin_converter.sv | 124 ++++++++++++
 tb/tb_bcd_to_bin_converter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, display glyph codes, and converter FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bcd_pkg;

  localparam int BCD_WIDTH = 4;

  // Non-numeric glyph codes shared with the font ROM and display path
  localparam logic [3:0] BCD_MINUS = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // A BCD digit is only legal in the range 0..9
  function automatic logic digit_invalid(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_sub3_adjust.sv
// Per-digit correction for reverse double-dabble: digits that reach 8+ after a shift lose 3.
// Latency: combinational.
// Backpressure: n/a.
module bcd_sub3_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // A digit >= 8 after a right shift carried a half-ten from above; remove the excess
  always_comb begin
    digit_out = (digit_in >= 4'd8) ? (digit_in - 4'd3) : digit_in;
  end

endmodule

// File: rtl/bcd_to_bin_converter.sv
// Signed BCD to two's-complement binary by reverse double-dabble, one bit per clock.
// Latency: result valid BIN_WIDTH edges after the accepting edge (BIN_WIDTH+1 counting it).
// Backpressure: result held while out_ready=0; no new word accepted until the result is taken.
module bcd_to_bin_converter
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BIN_WIDTH = DIGITS * 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGITS*4-1:0]     in_bcd,
  input  logic                    in_neg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIN_WIDTH-1:0]    out_data,
  output logic                    out_err
);

  localparam int BCD_W = DIGITS * BCD_WIDTH;
  localparam int SR_W  = BCD_W + BIN_WIDTH;
  localparam int CNT_W = $clog2(BIN_WIDTH);

  conv_state_t          state, state_nxt;
  logic [SR_W-1:0]      sr;
  logic [SR_W-1:0]      sr_shift;
  logic [SR_W-1:0]      sr_step;
  logic [CNT_W-1:0]     cnt;
  logic                 neg_q;
  logic                 err_q;
  logic                 in_digit_err;
  logic                 last_step;
  logic [BIN_WIDTH-1:0] bin_step;

  // Shift first, then correct every BCD digit of the shifted value in parallel
  assign sr_shift = sr >> 1;
  assign sr_step[BIN_WIDTH-1:0] = sr_shift[BIN_WIDTH-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_sub3_adjust u_adj (
      .digit_in  (sr_shift[BIN_WIDTH + i*BCD_WIDTH +: BCD_WIDTH]),
      .digit_out (sr_step [BIN_WIDTH + i*BCD_WIDTH +: BCD_WIDTH])
    );
  end

  assign bin_step  = sr_step[BIN_WIDTH-1:0];
  assign last_step = (cnt == CNT_W'(BIN_WIDTH - 1));

  // Flag the incoming word if any of its digits is outside 0..9
  always_comb begin
    in_digit_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(in_bcd[i*BCD_WIDTH +: BCD_WIDTH])) in_digit_err = 1'b1;
    end
  end

  // Next-state and handshake outputs; DONE never bypasses back to an accept
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: load on accept, step while shifting, latch the signed result on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      sr       <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr    <= {in_bcd, {BIN_WIDTH{1'b0}}};
            neg_q <= in_neg;
            err_q <= in_digit_err;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          sr  <= sr_step;
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            if (err_q) begin
              out_data <= '0;
              out_err  <= 1'b1;
            end else begin
              // Negating zero gives zero, so "-0" needs no special case
              out_data <= neg_q ? (-bin_step) : bin_step;
              out_err  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_converter.sv
module tb_bcd_to_bin_converter;

  localparam int DIGITS = 4;
  localparam int BW     = DIGITS * 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_bcd;
  logic          in_neg;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  bcd_to_bin_converter #(.DIGITS(DIGITS), .BIN_WIDTH(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .in_neg    (in_neg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the digits, then sign; any illegal digit forces 0 with err
  function automatic logic [BW-1:0] ref_model(input logic [BW-1:0] bcd, input logic neg,
                                              output logic err);
    int v;
    logic [BW-1:0] b;
    v   = 0;
    err = 1'b0;
    b   = bcd;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) err = 1'b1;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    if (err) return '0;
    return neg ? BW'(-v) : BW'(v);
  endfunction

  // Present a word and return at the negedge following the accepting edge
  task automatic start_word(input logic [BW-1:0] bcd, input logic neg, input string tag);
    int k;
    in_bcd   = bcd;
    in_neg   = neg;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready_seen"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (latency counted including the accepting edge) and check the result
  task automatic wait_result(input logic [BW-1:0] bcd, input logic neg, input string tag);
    int lat;
    logic exp_err;
    logic [BW-1:0] exp_data;
    exp_data = ref_model(bcd, neg, exp_err);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(BW + 1));
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  // Stall the consumer for 'hold' cycles, then take the result
  task automatic drain(input int hold, input string tag);
    logic [BW-1:0] held;
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_data"}, 32'(out_data), 32'(held));
      check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int stray;
    logic [BW-1:0] rb;
    logic rn;

    rst = 1'b1; in_valid = 1'b0; in_bcd = '0; in_neg = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);

    // Directed words
    start_word(16'h1234, 1'b0, "w1234"); wait_result(16'h1234, 1'b0, "w1234");
    check("w1234_abs", 32'(out_data), 32'h04D2);
    drain(0, "w1234");
    start_word(16'h9999, 1'b0, "w9999"); wait_result(16'h9999, 1'b0, "w9999");
    check("w9999_abs", 32'(out_data), 32'h270F);
    drain(1, "w9999");
    start_word(16'h0000, 1'b1, "wneg0"); wait_result(16'h0000, 1'b1, "wneg0");
    drain(0, "wneg0");
    start_word(16'h0042, 1'b1, "wm42"); wait_result(16'h0042, 1'b1, "wm42");
    check("wm42_abs", 32'(out_data), 32'hFFD6);
    drain(0, "wm42");
    start_word(16'h12A4, 1'b0, "wbad"); wait_result(16'h12A4, 1'b0, "wbad");
    check("wbad_abs_err", 32'(out_err), 32'd1);

    // Backpressure with a competing input word waiting
    in_bcd = 16'h0777; in_neg = 1'b0; in_valid = 1'b1;
    drain(5, "bp");
    check("bp_idle_after_hs", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_ready), 32'd0);
    wait_result(16'h0777, 1'b0, "w0777");
    check("w0777_abs", 32'(out_data), 32'h0309);
    drain(2, "w0777");

    // Reset during SHIFT cycle 7 drops the word
    start_word(16'h5555, 1'b0, "abort");
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("abort_no_stray", 32'(stray), 32'd0);
    start_word(16'h0001, 1'b0, "w0001"); wait_result(16'h0001, 1'b0, "w0001");
    check("w0001_abs", 32'(out_data), 32'h0001);
    drain(0, "w0001");

    // Randomized words, occasionally with an illegal digit
    for (int n = 0; n < 30; n++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if ($urandom_range(0, 9) == 0) rb[4*d +: 4] = 4'($urandom_range(10, 15));
        else                           rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      rn = 1'($urandom_range(0, 1));
      start_word(rb, rn, "rnd");
      wait_result(rb, rn, "rnd");
      drain(int'($urandom_range(0, 3)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
